// File: rtl/simon_pkg.sv
// Shared definitions for the SIMON64/96 CBC controller and its cipher core.
package simon_pkg;

  localparam int unsigned BLK_W  = 64;
  localparam int unsigned KEY_W  = 96;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ROUNDS = 42;
  localparam int unsigned CNT_W  = 4;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  typedef logic [ROUNDS-1:0][WORD_W-1:0] round_keys_t;

  // Rotate a 32-bit word left by s bits (0 < s < 32).
  function automatic logic [WORD_W-1:0] rol32(input logic [WORD_W-1:0] v, input int unsigned s);
    return (v << s) | (v >> (WORD_W - s));
  endfunction

  // Rotate a 32-bit word right by s bits (0 < s < 32).
  function automatic logic [WORD_W-1:0] ror32(input logic [WORD_W-1:0] v, input int unsigned s);
    return (v >> s) | (v << (WORD_W - s));
  endfunction

  // SIMON round function f(x) = (x<<<1 & x<<<8) ^ x<<<2.
  function automatic logic [WORD_W-1:0] simon_f(input logic [WORD_W-1:0] x);
    return (rol32(x, 1) & rol32(x, 8)) ^ rol32(x, 2);
  endfunction

endpackage

// File: rtl/simon64_96.sv
// Fully unrolled combinational SIMON64/96 core (42 rounds).
// key = {k2, k1, k0}, inText/outText = {x, y}; encryptOrDecrypt 1 = encrypt.
module simon64_96
  import simon_pkg::*;
(
  input  logic             encryptOrDecrypt,
  input  logic [BLK_W-1:0] inText,
  input  logic [KEY_W-1:0] key,
  output logic [BLK_W-1:0] outText
);

  // Constant sequence z2, leftmost character is z2[0].
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

  // Key expansion for m = 3 words; constant c = 2^32 - 4 folded as ~k ^ 3.
  function automatic round_keys_t expand_key(input logic [KEY_W-1:0] k);
    round_keys_t       rk;
    logic [WORD_W-1:0] t;
    rk    = '0;
    rk[0] = k[31:0];
    rk[1] = k[63:32];
    rk[2] = k[95:64];
    for (int i = 3; i < int'(ROUNDS); i++) begin
      t     = ror32(rk[i-1], 3);
      t     = t ^ ror32(t, 1);
      rk[i] = ~rk[i-3] ^ t ^ {31'b0, Z2[61-(i-3)]} ^ 32'd3;
    end
    return rk;
  endfunction

  round_keys_t rk_all;

  assign rk_all = expand_key(key);

  // Round network: forward rounds for encrypt, inverse rounds in reverse key order for decrypt.
  always_comb begin : p_rounds
    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] y;
    logic [WORD_W-1:0] t;
    x = inText[63:32];
    y = inText[31:0];
    t = '0;
    if (encryptOrDecrypt) begin
      for (int r = 0; r < int'(ROUNDS); r++) begin
        t = x;
        x = y ^ simon_f(x) ^ rk_all[r];
        y = t;
      end
    end else begin
      for (int r = int'(ROUNDS) - 1; r >= 0; r--) begin
        t = y;
        y = x ^ simon_f(y) ^ rk_all[r];
        x = t;
      end
    end
    outText = {x, y};
  end

endmodule

// File: rtl/simon64_96_cbc_ctrl.sv
// CBC-mode encrypt/decrypt controller around the combinational SIMON64/96 core.
// Core inputs are registered at accept and the result is captured after a
// fixed number of settle edges, treating the core as a multicycle path.
module simon64_96_cbc_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4   // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  input  logic             iv_load,
  input  logic [BLK_W-1:0] iv_in,
  input  logic             mode_dec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_q;
  logic [KEY_W-1:0] key_q;
  logic [BLK_W-1:0] chain_q;
  logic [BLK_W-1:0] core_in_q;
  logic [BLK_W-1:0] ct_q;
  logic [BLK_W-1:0] out_data_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [BLK_W-1:0] core_out;
  logic [BLK_W-1:0] core_in_d;
  logic [BLK_W-1:0] result_d;
  logic [BLK_W-1:0] chain_d;
  logic             accept;

  simon64_96 u_core (
    .encryptOrDecrypt (~mode_q),
    .inText           (core_in_q),
    .key              (key_q),
    .outText          (core_out)
  );

  // Loads pre-empt data accept so a key/IV change never races a block.
  assign in_ready = (state_q == ST_IDLE) & ~key_load & ~iv_load;
  assign accept   = in_valid & in_ready;

  // Encrypt whitens the plaintext with the chain; decrypt feeds the ciphertext straight in.
  assign core_in_d = (mode_dec == MODE_DEC) ? in_data : (in_data ^ chain_q);

  // Decrypt un-whitens the core output; the next chain is the ciphertext of this block.
  assign result_d = (mode_q == MODE_DEC) ? (core_out ^ chain_q) : core_out;
  assign chain_d  = (mode_q == MODE_DEC) ? ct_q : core_out;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

  // Controller FSM with its datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mode_q      <= MODE_ENC;
      key_q       <= '0;
      chain_q     <= '0;
      core_in_q   <= '0;
      ct_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_load) begin
            key_q <= key_in;
          end
          if (iv_load) begin
            chain_q <= iv_in;
          end
          if (accept) begin
            mode_q    <= mode_dec;
            core_in_q <= core_in_d;
            if (mode_dec == MODE_DEC) begin
              ct_q <= in_data;
            end
            cnt_q   <= CNT_START;
            busy_q  <= 1'b1;
            state_q <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (cnt_q == '0) begin
            out_data_q  <= result_d;
            chain_q     <= chain_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon64_96_cbc_ctrl.sv
// Self-checking bench for simon64_96_cbc_ctrl: directed CBC vectors, a
// transaction-level reference model, and a per-cycle output comparison.
module tb_simon64_96_cbc_ctrl;

  localparam int SETTLE = 4;

  localparam logic [95:0] KEY1 = 96'h131211100b0a090803020100;
  localparam logic [95:0] KEY2 = 96'hfedcba98765432100f1e2d3c;
  localparam logic [63:0] PT1  = 64'h6f7220676e696c63;
  localparam logic [63:0] PT2  = 64'h33d0c2187f73e3ab;
  localparam logic [63:0] CT1  = 64'h5ca2e27f111a8fc8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_load;
  logic [95:0] key_in;
  logic        iv_load;
  logic [63:0] iv_in;
  logic        mode_dec;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  simon64_96_cbc_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .iv_load   (iv_load),
    .iv_in     (iv_in),
    .mode_dec  (mode_dec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference cipher (rolling key window) ----------------
  function automatic logic [31:0] rl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [31:0] fr(input logic [31:0] x);
    return (rl(x, 1) & rl(x, 8)) ^ rl(x, 2);
  endfunction

  // ror3(c) ^ ror4(c), the m=3 key-schedule mix term
  function automatic logic [31:0] gk(input logic [31:0] c);
    return rl(c, 29) ^ rl(c, 28);
  endfunction

  function automatic logic zbit(input int i);
    logic [61:0] zz;
    zz = 62'b10101111011100000011010010011000101000010001111110010110110011;
    return zz[61 - i];
  endfunction

  function automatic logic [63:0] ref_enc(input logic [63:0] p, input logic [95:0] k);
    logic [31:0] a, b, c, nk, x, y, t;
    a = k[31:0]; b = k[63:32]; c = k[95:64];
    x = p[63:32]; y = p[31:0];
    for (int i = 0; i < 42; i++) begin
      t = x;
      x = y ^ fr(x) ^ a;
      y = t;
      nk = ~a ^ gk(c) ^ {31'b0, zbit(i)} ^ 32'd3;
      a = b; b = c; c = nk;
    end
    return {x, y};
  endfunction

  function automatic logic [63:0] ref_dec(input logic [63:0] q, input logic [95:0] k);
    logic [31:0] a, b, c, nk, x, y, t;
    a = k[31:0]; b = k[63:32]; c = k[95:64];
    for (int i = 0; i < 39; i++) begin
      nk = ~a ^ gk(c) ^ {31'b0, zbit(i)} ^ 32'd3;
      a = b; b = c; c = nk;
    end
    x = q[63:32]; y = q[31:0];
    for (int r = 41; r >= 0; r--) begin
      t = y;
      y = x ^ fr(y) ^ c;
      x = t;
      nk = (r >= 3) ? ~(c ^ gk(b) ^ {31'b0, zbit(r - 3)} ^ 32'd3) : 32'd0;
      c = b; b = a; a = nk;
    end
    return {x, y};
  endfunction

  // ---------------- transaction-level controller model ----------------
  logic [95:0] m_key;
  logic [63:0] m_chain, m_out, p_out, p_chain;
  bit          m_busy, m_valid;
  int          m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_key   <= '0;
      m_chain <= '0;
      m_out   <= '0;
      p_out   <= '0;
      p_chain <= '0;
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_left  <= 0;
    end else if (!m_busy) begin
      if (key_load) m_key <= key_in;
      if (iv_load) m_chain <= iv_in;
      if (in_valid && !key_load && !iv_load) begin
        m_busy <= 1'b1;
        m_left <= SETTLE;
        if (mode_dec) begin
          p_out   <= ref_dec(in_data, m_key) ^ m_chain;
          p_chain <= in_data;
        end else begin
          p_out   <= ref_enc(in_data ^ m_chain, m_key);
          p_chain <= ref_enc(in_data ^ m_chain, m_key);
        end
      end
    end else if (!m_valid) begin
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_out   <= p_out;
        m_chain <= p_chain;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_in_ready", 64'(in_ready), 64'(!m_busy && !key_load && !iv_load));
      chk("cyc_busy", 64'(busy), 64'(m_busy));
      chk("cyc_out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) chk("cyc_out_data", out_data, m_out);
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit kl, input logic [95:0] k, input bit il, input logic [63:0] iv);
    key_load = kl; key_in = k; iv_load = il; iv_in = iv;
    tick();
    key_load = 1'b0; iv_load = 1'b0;
    $display("load key_load=%0b key=%h iv_load=%0b iv=%h", kl, k, il, iv);
  endtask

  // One block: accept, optional disturbance during settle, optional backpressure.
  task automatic run_block(input string name, input logic [63:0] din, input bit dec,
                           input bit has_exp, input logic [63:0] exp,
                           input int hold_cycles, input bit disturb);
    int n;
    bit found;
    logic [63:0] want;
    in_data = din; mode_dec = dec; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    mode_dec = ~dec;
    n = 0; found = 1'b0;
    while (n < 40 && !found) begin
      if (disturb && n == 1) begin
        key_load = 1'b1; key_in = KEY2; iv_load = 1'b1; iv_in = '1; in_valid = 1'b1;
      end
      tick();
      n++;
      if (disturb && n == 2) begin
        key_load = 1'b0; iv_load = 1'b0; in_valid = 1'b0;
      end
      if (out_valid) found = 1'b1;
    end
    key_load = 1'b0; iv_load = 1'b0; in_valid = 1'b0;
    chk({name, "_latency"}, 64'(n), 64'(SETTLE));
    want = has_exp ? exp : m_out;
    chk({name, "_data"}, out_data, want);
    for (int h = 0; h < hold_cycles; h++) begin
      in_valid = 1'b1;
      tick();
      chk({name, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_hold_ready"}, 64'(in_ready), 64'd0);
      chk({name, "_hold_data"}, out_data, want);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_release_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_release_busy"}, 64'(busy), 64'd0);
    $display("block %s dec=%0b in=%h out=%h latency=%0d", name, dec, din, want, n);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; key_load = 1'b0; key_in = '0; iv_load = 1'b0; iv_in = '0;
    mode_dec = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reference model pinned against the published vector.
    chk("ref_enc_vector", ref_enc(PT1, KEY1), CT1);
    chk("ref_dec_vector", ref_dec(CT1, KEY1), PT1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    $display("reset released");

    // Test 1/2: encrypt chain from IV 0.
    load(1'b1, KEY1, 1'b1, 64'd0);
    run_block("t1_enc", PT1, 1'b0, 1'b1, CT1, 0, 1'b0);
    run_block("t2_enc", PT2, 1'b0, 1'b1, CT1, 0, 1'b0);

    // Test 3: decrypt chain from IV 0.
    load(1'b0, '0, 1'b1, 64'd0);
    run_block("t3_dec1", CT1, 1'b1, 1'b1, PT1, 0, 1'b0);
    run_block("t3_dec2", CT1, 1'b1, 1'b1, PT2, 0, 1'b0);

    // Test 4: backpressure; chain is CT1 after the decrypts.
    run_block("t4_bp", PT2, 1'b0, 1'b1, CT1, 6, 1'b0);

    // Test 5: loads during settle are ignored.
    load(1'b0, '0, 1'b1, 64'd0);
    run_block("t5_ign", PT1, 1'b0, 1'b1, CT1, 0, 1'b1);

    // Test 5b: key_load with in_valid in IDLE -> load first, accept next cycle.
    key_in = KEY2; key_load = 1'b1; in_valid = 1'b1; in_data = PT1; mode_dec = 1'b0;
    #1;
    chk("t5b_in_ready_during_load", 64'(in_ready), 64'd0);
    tick();
    key_load = 1'b0;
    #1;
    chk("t5b_in_ready_after_load", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (n < 40 && !out_valid) begin
      tick();
      n++;
    end
    chk("t5b_latency", 64'(n), 64'(SETTLE));
    chk("t5b_data_key2", out_data, ref_enc(PT1 ^ CT1, KEY2));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("block t5b key2 in=%h out=%h", PT1, ref_enc(PT1 ^ CT1, KEY2));

    // Test 6: reset mid-settle, then reload key only.
    in_data = PT2; mode_dec = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_out_data", out_data, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("mid-settle reset applied and released");
    load(1'b1, KEY1, 1'b0, '0);
    run_block("t6_enc", PT1, 1'b0, 1'b1, CT1, 0, 1'b0);

    repeat (3) tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
